// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN_DEF      default instruction / PC width
//   RESET_PC_DEF  default PC loaded on reset
//   PC_STEP_DEF   default PC increment per fetched word
//   NOP_INSTR     canonical NOP encoding (addi x0,x0,0)
//   cnt_w()       width of an occupancy counter able to hold 0..depth
package fetch_prefetch_queue_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs for the fetch queue.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears storage too)
//   en         clock enable; 0 freezes all state
//   push/pop   write tail / remove head (caller guarantees no overflow/underflow)
//   flush      empties the queue; dominates push and pop
//   wdata      entry to write
//   rdata      head entry, combinational from storage
//   count      current occupancy
module fetch_prefetch_queue_sync_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      else      wr_ptr_d = wr_ptr_q;
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      else      rd_ptr_d = rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and pointer registers; flush leaves storage contents alone
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (en) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wdata;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: sequential PC generation, 1-cycle-latency
// instruction memory requests, a DEPTH-entry prefetch queue and a
// valid/ready hand-off to decode. A redirect flushes the queue and discards
// any response belonging to the old path.
// Ports:
//   clk, rst, clk_en          clock, sync active-high reset, clock enable
//   imem_req, imem_addr       request strobe and fetch PC
//   imem_rdata                read data, valid the cycle after imem_req
//   redirect, redirect_pc     flush and restart fetch at redirect_pc
//   id_valid/id_ready         decode handshake; id_instr/id_pc = queue head
//   q_count                   queue occupancy
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned      PC_STEP  = PC_STEP_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [XLEN-1:0]          id_instr,
  output logic [XLEN-1:0]          id_pc,
  output logic [cnt_w(DEPTH)-1:0]  q_count
);

  localparam int unsigned  CW      = cnt_w(DEPTH);
  localparam logic [CW:0]  DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              drop_q, drop_d;
  logic [CW:0]       occ_s;
  logic              issue_s, push_s, pop_s;
  logic [2*XLEN-1:0] head_s;

  // Credit check, handshake qualification and fetch next-state
  always_comb begin
    // Occupancy plus the outstanding request: a request is only issued when
    // its response is guaranteed a free slot, so the queue never overflows.
    occ_s = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};
    if (clk_en && !rst && !redirect && (occ_s < DEPTH_C)) issue_s = 1'b1;
    else                                                   issue_s = 1'b0;

    push_s = inflight_q && !drop_q && !redirect;
    pop_s  = id_valid && id_ready && !redirect;

    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    drop_d     = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      drop_d     = inflight_q;
    end else if (issue_s) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      req_pc_d   = fetch_pc_q;
      inflight_d = 1'b1;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // Fetch state registers, frozen while clk_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= {XLEN{1'b0}};
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else if (clk_en) begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_prefetch_queue_sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .en    (clk_en),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect),
    .wdata ({req_pc_q, imem_rdata}),
    .rdata (head_s),
    .count (q_count)
  );

  assign imem_req  = issue_s;
  assign imem_addr = fetch_pc_q;
  assign id_valid  = (q_count != {CW{1'b0}});
  assign id_pc     = head_s[2*XLEN-1:XLEN];
  assign id_instr  = head_s[XLEN-1:0];

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue. Expected PCs are pushed to a
// scoreboard queue when reset/redirect stimulus is applied and popped when
// decode accepts an instruction. Memory returns addr ^ 0xA5A5_0000.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, clk_en, redirect, id_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_instr, id_pc;
  logic [31:0] imem_rdata = 32'h0;
  logic [2:0]  q_count;

  logic        rst_w = 1'b1, clk_en_w = 1'b1, redirect_w = 1'b0, id_ready_w = 1'b0;
  logic [31:0] redirect_pc_w = 32'h0;
  logic        imem_req_w, id_valid_w;
  logic [31:0] imem_addr_w, id_instr_w, id_pc_w;
  logic [31:0] imem_rdata_w = 32'h0;
  logic [2:0]  q_count_w;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w_q[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .q_count(q_count)
  );

  fetch_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_w (
    .clk(clk), .rst(rst_w), .clk_en(clk_en_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .id_valid(id_valid_w), .id_ready(id_ready_w), .id_instr(id_instr_w), .id_pc(id_pc_w),
    .q_count(q_count_w)
  );

  // Instruction memories: 1-cycle read latency, gated by the clock enable
  always @(posedge clk) begin
    if (clk_en && imem_req) imem_rdata <= imem_addr ^ KEY;
    if (clk_en_w && imem_req_w) imem_rdata_w <= imem_addr_w ^ KEY;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || q_count !== 3'd0 || id_pc !== 32'h0 || id_instr !== 32'h0) begin
      bad++;
      $display("FAIL reset_state got req=%b valid=%b cnt=%0d pc=%h instr=%h want all zero",
               imem_req, id_valid, q_count, id_pc, id_instr);
    end
    rst = 1'b0;
    refill(32'h0);
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL first_req got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
    end
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL valid_c0 got %b want 0", id_valid);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL valid_c1 got %b want 0", id_valid);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== KEY) begin
      bad++;
      $display("FAIL valid_c2 got valid=%b pc=%h instr=%h want 1 00000000 %h", id_valid, id_pc, id_instr, KEY);
    end
    next_cycle();
  endtask

  task automatic test_streaming();
    id_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (id_valid !== 1'b1) begin
        bad++; $display("FAIL stream_valid cycle %0d got %b want 1", i, id_valid);
      end else begin
        exp_pc = exp_q.pop_front();
        if (id_pc !== exp_pc || id_instr !== (exp_pc ^ KEY)) begin
          bad++;
          $display("FAIL stream_data got pc=%h instr=%h want pc=%h instr=%h", id_pc, id_instr, exp_pc, exp_pc ^ KEY);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (q_count > 3'd4) begin
        bad++; $display("FAIL bp_count_bound got %0d want <=4", q_count);
      end
      if (i == 9) begin
        total++;
        if (q_count !== 3'd4 || imem_req !== 1'b0 || id_pc !== exp_q[0]) begin
          bad++;
          $display("FAIL bp_saturate got cnt=%0d req=%b pc=%h want 4 0 %h", q_count, imem_req, id_pc, exp_q[0]);
        end
      end
      next_cycle();
    end
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (id_valid !== 1'b1) begin
        bad++; $display("FAIL bp_resume_valid got %b want 1", id_valid);
      end else begin
        exp_pc = exp_q.pop_front();
        if (id_pc !== exp_pc || id_instr !== (exp_pc ^ KEY)) begin
          bad++; $display("FAIL bp_resume_data got pc=%h instr=%h want pc=%h", id_pc, id_instr, exp_pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic collect(input int n, input int budget, input string name);
    int got;
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (id_valid === 1'b1 && id_ready === 1'b1 && clk_en === 1'b1) begin
        exp_pc = exp_q.pop_front();
        got++;
        total++;
        if (id_pc !== exp_pc || id_instr !== (exp_pc ^ KEY)) begin
          bad++; $display("FAIL %s got pc=%h instr=%h want pc=%h", name, id_pc, id_instr, exp_pc);
        end
      end
      next_cycle();
    end
    total++;
    if (got != n) begin
      bad++; $display("FAIL %s_timeout got %0d items want %0d", name, got, n);
    end
  endtask

  task automatic test_redirect_inflight();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (id_valid === 1'b1) begin
        exp_pc = exp_q.pop_front();
        total++;
        if (id_pc !== exp_pc) begin
          bad++; $display("FAIL pre_redirect got pc=%h want %h", id_pc, exp_pc);
        end
      end
      seen = (imem_req === 1'b1);
      next_cycle();
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL redirect_setup got no request want one in flight");
    end
    // Redirect cycle: a pop and a response push both coincide with it.
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL redirect_noissue got req=%b want 0", imem_req);
    end
    next_cycle();
    redirect = 1'b0;
    refill(32'h0000_0100);
    @(negedge clk);
    total++;
    if (q_count !== 3'd0 || id_valid !== 1'b0) begin
      bad++; $display("FAIL redirect_flush got cnt=%0d valid=%b want 0 0", q_count, id_valid);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
      bad++; $display("FAIL redirect_newreq got req=%b addr=%h want 1 00000100", imem_req, imem_addr);
    end
    next_cycle();
    collect(4, 12, "redirect_seq");
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    next_cycle();
    redirect_pc = 32'h0000_0300;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL b2b_noissue got req=%b want 0", imem_req);
    end
    next_cycle();
    redirect = 1'b0;
    refill(32'h0000_0300);
    @(negedge clk);
    total++;
    if (q_count !== 3'd0 || imem_addr !== 32'h0000_0300) begin
      bad++; $display("FAIL b2b_last_wins got cnt=%0d addr=%h want 0 00000300", q_count, imem_addr);
    end
    next_cycle();
    collect(6, 14, "b2b_seq");
  endtask

  task automatic test_clk_en();
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== exp_q[0] || id_instr !== (exp_q[0] ^ KEY)) begin
        bad++;
        $display("FAIL clken_freeze got req=%b valid=%b pc=%h want 0 1 %h", imem_req, id_valid, id_pc, exp_q[0]);
      end
      next_cycle();
    end
    clk_en = 1'b1;
    collect(6, 10, "clken_resume");
  endtask

  task automatic test_wrap();
    total++;
    if (q_count_w !== 3'd0 || id_valid_w !== 1'b0) begin
      bad++; $display("FAIL wrap_reset got cnt=%0d valid=%b want 0 0", q_count_w, id_valid_w);
    end
    id_ready_w = 1'b1;
    rst_w = 1'b0;
    exp_w_q.delete();
    exp_w_q.push_back(32'hFFFF_FFF8);
    exp_w_q.push_back(32'hFFFF_FFFC);
    exp_w_q.push_back(32'h0000_0000);
    exp_w_q.push_back(32'h0000_0004);
    for (int i = 0; i < 12 && exp_w_q.size() > 0; i++) begin
      @(negedge clk);
      if (id_valid_w === 1'b1) begin
        exp_pc = exp_w_q.pop_front();
        total++;
        if (id_pc_w !== exp_pc || id_instr_w !== (exp_pc ^ KEY)) begin
          bad++; $display("FAIL wrap_seq got pc=%h instr=%h want pc=%h", id_pc_w, id_instr_w, exp_pc);
        end
      end
      next_cycle();
    end
    total++;
    if (exp_w_q.size() != 0) begin
      bad++; $display("FAIL wrap_timeout got %0d items left want 0", exp_w_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_back_to_back();
    test_clk_en();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
